syscfg_reg_slave: RTL
=====================

SYSCFG_REG_SLAVE -- requirements
Module: syscfg_reg_slave

Interface
REQ-001 SHALL have parameter BUILD_TIMESTAMP, default 32'h01010000, value read at offset 0x000.
REQ-002 SHALL have parameter RST_CYCLES, default 16, reset pulse length in clocks (legal range 2..255).
REQ-003 SHALL have one clock and an asynchronous, active-high reset:
- axil_aclk  in  1  sole clock.
- axil_rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have the AXI4-Lite write ports:
- s_axil_awvalid/awready  in/out  1  write address handshake.
- s_axil_awaddr  in  12  byte address.
- s_axil_wvalid/wready  in/out  1  write data handshake.
- s_axil_wdata  in  32  write data; wstrb is not present.
- s_axil_bvalid/bready  out/in  1  write response handshake.
- s_axil_bresp  out  2  write response code.
REQ-005 SHALL have the AXI4-Lite read ports:
- s_axil_arvalid/arready  in/out  1  read address handshake.
- s_axil_araddr  in  12  byte address.
- s_axil_rvalid/rready  out/in  1  read data handshake.
- s_axil_rdata  out  32  read data.
- s_axil_rresp  out  2  read response code.
REQ-006 SHALL have the reset-domain ports:
- sys_rst, shell_rst, user_rst  out  1 each  domain reset requests.
- sys_rst_done, shell_rst_done, user_rst_done  in  1 each  domain acknowledges, already synchronous to axil_aclk.

Function
REQ-007 Register map SHALL be:
- 0x000 build timestamp, RO.
- 0x004 system reset, WO.
- 0x008 system done, RO.
- 0x00C shell reset, WO.
- 0x010 shell done, RO.
- 0x014 user reset, WO.
- 0x018 user done, RO.
REQ-008 Write FSM SHALL have states W_IDLE and W_RESP.
REQ-009 In W_IDLE with awvalid&&wvalid, awready and wready SHALL pulse high together for one cycle and the FSM SHALL move to W_RESP.
REQ-010 In W_RESP, bvalid SHALL be high and held until bready, then the FSM SHALL return to W_IDLE; awready/wready SHALL stay low in W_RESP.
REQ-011 If only one of awvalid or wvalid is high, the block SHALL not accept either channel.
REQ-012 Read FSM SHALL have states R_IDLE and R_DATA.
REQ-013 In R_IDLE with arvalid, arready SHALL pulse for one cycle; rdata/rresp SHALL be registered and rvalid SHALL rise the next cycle (R_DATA).
REQ-014 In R_DATA, rdata/rvalid SHALL be held stable until rready, then the FSM SHALL return to R_IDLE.
REQ-015 Read and write FSMs SHALL run independently; simultaneous accept SHALL be legal, with one outstanding transaction per direction.
REQ-016 Writing any nonzero wdata to a reset register SHALL load that domain's 8-bit counter with RST_CYCLES, assert its rst output from the next cycle, and clear its done flag.
REQ-017 Writing zero to a reset register SHALL have no effect.
REQ-018 A write to 0x004 SHALL also trigger the shell and user domains.
REQ-019 A domain's rst output SHALL be high while its counter is nonzero; the counter SHALL decrement by one per cycle to 0, giving exactly RST_CYCLES high cycles.
REQ-020 Done flag SHALL set on the first cycle the counter is 0 and the domain's *_done input is high; it SHALL then hold until the next trigger.
REQ-021 A retrigger during an active pulse SHALL reload the counter to RST_CYCLES, extending the pulse with no glitch low.
REQ-022 A done register read SHALL return {31'b0, done flag}.
REQ-023 Reads of the WO offsets and unmapped reads SHALL return 0; writes to RO or unmapped offsets SHALL be ignored.
REQ-024 The block SHALL decode addresses from bits [11:2] only.

Reset
REQ-025 On axil_rst, all AXI ready/valid outputs SHALL be 0, bresp/rresp/rdata SHALL be 0, and the FSMs SHALL be in W_IDLE/R_IDLE.
REQ-026 On axil_rst, counters SHALL be 0, sys_rst/shell_rst/user_rst SHALL be 0, and done flags SHALL be 0.
REQ-027 Reset asserted mid-transaction SHALL abort the transaction with no response issued after release.

Configuration
REQ-028 With SYSCFG_SLVERR_EN defined, unmapped or wrong-direction accesses SHALL return resp 2'b10 (SLVERR), with rdata 0 on reads.
REQ-029 Without SYSCFG_SLVERR_EN, all responses SHALL be 2'b00 (OKAY).

Verification
REQ-030 Read 0x000 -> rdata 32'h01010000, rresp OKAY, rvalid one cycle after arready.
REQ-031 Write 0x00C=32'hffff_ffff with shell_rst_done tied 1 -> shell_rst high exactly 16 cycles; 0x010 reads 0 during the pulse and 1 after.
REQ-032 Write 0x004=1 -> all three rst outputs high 16 cycles; with user_rst_done held 0, 0x018 stays 0 until user_rst_done rises, then reads 1.
REQ-033 Present awvalid 5 cycles before wvalid -> no awready until wvalid, then awready and wready together.
REQ-034 Retrigger user reset at pulse cycle 10 -> user_rst high 26 cycles continuously.
REQ-035 Read 0x01C with SYSCFG_SLVERR_EN -> rresp 2'b10, rdata 0; read 0x01C without it -> rresp 2'b00, rdata 0.

Source files
------------

// File: rtl/syscfg_reg_slave.sv
// AXI4-Lite register slave that issues timed reset pulses to the sys/shell/user domains.
// Define SYSCFG_SLVERR_EN to answer unmapped or wrong-direction accesses with SLVERR.
module syscfg_reg_slave #(
    parameter logic [31:0] BUILD_TIMESTAMP = 32'h01010000,
    parameter int          RST_CYCLES      = 16
) (
    input  logic        axil_aclk,
    input  logic        axil_rst,

    input  logic        s_axil_awvalid,
    output logic        s_axil_awready,
    input  logic [11:0] s_axil_awaddr,
    input  logic        s_axil_wvalid,
    output logic        s_axil_wready,
    input  logic [31:0] s_axil_wdata,
    output logic        s_axil_bvalid,
    input  logic        s_axil_bready,
    output logic [1:0]  s_axil_bresp,

    input  logic        s_axil_arvalid,
    output logic        s_axil_arready,
    input  logic [11:0] s_axil_araddr,
    output logic        s_axil_rvalid,
    input  logic        s_axil_rready,
    output logic [31:0] s_axil_rdata,
    output logic [1:0]  s_axil_rresp,

    output logic        sys_rst,
    output logic        shell_rst,
    output logic        user_rst,
    input  logic        sys_rst_done,
    input  logic        shell_rst_done,
    input  logic        user_rst_done
);

    localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef SYSCFG_SLVERR_EN
    localparam logic [1:0] RESP_ERR  = 2'b10;
`else
    localparam logic [1:0] RESP_ERR  = 2'b00;
`endif
    localparam logic [7:0] RST_LOAD  = 8'(RST_CYCLES);

    typedef enum logic { W_IDLE, W_RESP } w_state_t;
    typedef enum logic { R_IDLE, R_DATA } r_state_t;

    w_state_t    w_state;
    r_state_t    r_state;

    logic [9:0]  w_idx;
    logic [9:0]  r_idx;
    logic        w_fire;
    logic        r_fire;
    logic        w_legal;
    logic        w_nonzero;
    logic [2:0]  trig;
    logic [31:0] rd_data;
    logic        rd_legal;

    logic [7:0]  cnt [3];
    logic [2:0]  done_q;
    logic [2:0]  done_in;

    // Byte-lane bits of the address carry no meaning for 32-bit registers.
    logic        unused_addr_bits;
    assign unused_addr_bits = ^{s_axil_awaddr[1:0], s_axil_araddr[1:0]};

    assign w_idx     = s_axil_awaddr[11:2];
    assign r_idx     = s_axil_araddr[11:2];
    assign done_in   = {user_rst_done, shell_rst_done, sys_rst_done};
    assign w_nonzero = |s_axil_wdata;

    // Both write channels must be present before either is accepted.
    assign w_fire         = (w_state == W_IDLE) && s_axil_awvalid && s_axil_wvalid;
    assign s_axil_awready = w_fire;
    assign s_axil_wready  = w_fire;

    assign r_fire         = (r_state == R_IDLE) && s_axil_arvalid;
    assign s_axil_arready = r_fire;

    assign w_legal = (w_idx == 10'd1) || (w_idx == 10'd3) || (w_idx == 10'd5);

    always_comb begin
        trig = 3'b000;
        if (w_fire && w_nonzero) begin
            case (w_idx)
                10'd1:   trig = 3'b111;
                10'd3:   trig = 3'b010;
                10'd5:   trig = 3'b100;
                default: trig = 3'b000;
            endcase
        end
    end

    always_comb begin
        rd_data  = 32'd0;
        rd_legal = 1'b1;
        case (r_idx)
            10'd0:   rd_data = BUILD_TIMESTAMP;
            10'd2:   rd_data = {31'd0, done_q[0]};
            10'd4:   rd_data = {31'd0, done_q[1]};
            10'd6:   rd_data = {31'd0, done_q[2]};
            default: rd_legal = 1'b0;
        endcase
    end

    always_ff @(posedge axil_aclk or posedge axil_rst) begin
        if (axil_rst) begin
            w_state       <= W_IDLE;
            s_axil_bvalid <= 1'b0;
            s_axil_bresp  <= RESP_OKAY;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (w_fire) begin
                        w_state       <= W_RESP;
                        s_axil_bvalid <= 1'b1;
                        s_axil_bresp  <= w_legal ? RESP_OKAY : RESP_ERR;
                    end
                end
                W_RESP: begin
                    if (s_axil_bready) begin
                        w_state       <= W_IDLE;
                        s_axil_bvalid <= 1'b0;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge axil_aclk or posedge axil_rst) begin
        if (axil_rst) begin
            r_state       <= R_IDLE;
            s_axil_rvalid <= 1'b0;
            s_axil_rdata  <= 32'd0;
            s_axil_rresp  <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (r_fire) begin
                        r_state       <= R_DATA;
                        s_axil_rvalid <= 1'b1;
                        s_axil_rdata  <= rd_data;
                        s_axil_rresp  <= rd_legal ? RESP_OKAY : RESP_ERR;
                    end
                end
                R_DATA: begin
                    if (s_axil_rready) begin
                        r_state       <= R_IDLE;
                        s_axil_rvalid <= 1'b0;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // A trigger reloads the counter even mid-pulse, so a retrigger only stretches the pulse.
    always_ff @(posedge axil_aclk or posedge axil_rst) begin
        if (axil_rst) begin
            for (int i = 0; i < 3; i++) cnt[i] <= 8'd0;
            done_q <= 3'b000;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (trig[i]) begin
                    cnt[i]    <= RST_LOAD;
                    done_q[i] <= 1'b0;
                end else if (cnt[i] != 8'd0) begin
                    cnt[i] <= cnt[i] - 8'd1;
                end else if (done_in[i]) begin
                    done_q[i] <= 1'b1;
                end
            end
        end
    end

    assign sys_rst   = (cnt[0] != 8'd0);
    assign shell_rst = (cnt[1] != 8'd0);
    assign user_rst  = (cnt[2] != 8'd0);

endmodule
